// File: rtl/moore_sec_pkg.sv
// Shared types and constants for the 1011 Moore sequence detector.
package moore_sec_pkg;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    localparam logic [3:0] PATTERN  = 4'b1011;
    localparam int         DETCNT_W = 8;

    localparam logic [DETCNT_W-1:0] DETCNT_ONE = {{(DETCNT_W-1){1'b0}}, 1'b1};
    localparam logic [DETCNT_W-1:0] DETCNT_MAX = {DETCNT_W{1'b1}};

endpackage

// File: rtl/moore_sec_detector.sv
// Moore detector for serial pattern 1011 with registered, glitch-free output.
// Optional macro MOORE_SEC_DETCNT_EN adds a saturating detection counter port.
module moore_sec_detector
    import moore_sec_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    output logic                out
`ifdef MOORE_SEC_DETCNT_EN
    ,
    output logic [DETCNT_W-1:0] det_count
`endif
);

    state_t r_state;
    state_t w_next;
    logic   r_out;

    // Next-state decode; illegal encodings fall back to S0.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0: begin
                if (in) w_next = S1;
                else    w_next = S0;
            end
            S1: begin
                if (in) w_next = S1;
                else    w_next = S2;
            end
            S2: begin
                if (in) w_next = S3;
                else    w_next = S0;
            end
            S3: begin
                if (in) w_next = S4;
                else    w_next = S2;
            end
            S4: begin
                if (in)           w_next = S1;
                else if (OVERLAP) w_next = S2;
                else              w_next = S0;
            end
            default: w_next = S0;
        endcase
    end

    // State register and output flag loaded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= (w_next == S4);
        end
    end

    assign out = r_out;

`ifdef MOORE_SEC_DETCNT_EN
    logic [DETCNT_W-1:0] r_det_count;

    // S4 never follows itself, so every next==S4 is a fresh entry into S4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_det_count <= {DETCNT_W{1'b0}};
        end else if ((w_next == S4) && (r_det_count != DETCNT_MAX)) begin
            r_det_count <= r_det_count + DETCNT_ONE;
        end else begin
            r_det_count <= r_det_count;
        end
    end

    assign det_count = r_det_count;
`endif

endmodule

// File: tb/tb_moore_sec_detector.sv
// Directed self-checking bench for moore_sec_detector (overlap and non-overlap instances).
module tb_moore_sec_detector;
    import moore_sec_pkg::*;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic in_s = 1'b0;
    logic out_ov;
    logic out_no;
`ifdef MOORE_SEC_DETCNT_EN
    logic [DETCNT_W-1:0] cnt_ov;
    logic [DETCNT_W-1:0] cnt_no;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    moore_sec_detector #(.OVERLAP(1'b1)) dut_ov (
        .clk       (clk),
        .rst       (rst),
        .in        (in_s),
        .out       (out_ov)
`ifdef MOORE_SEC_DETCNT_EN
        ,
        .det_count (cnt_ov)
`endif
    );

    moore_sec_detector #(.OVERLAP(1'b0)) dut_no (
        .clk       (clk),
        .rst       (rst),
        .in        (in_s),
        .out       (out_no)
`ifdef MOORE_SEC_DETCNT_EN
        ,
        .det_count (cnt_no)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        in_s = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_ov", 32'(out_ov), 32'd0);
        check_eq("rst_state_ov", 32'(dut_ov.r_state), 32'(S0));
        @(negedge clk);
        rst  = 1'b1;
        in_s = 1'b0;
    endtask

    // Bit n-1 is applied first; expectations use the same ordering.
    task automatic run_vec(input string tag, input logic [15:0] bits, input int n,
                           input logic [15:0] exp_ov, input logic [15:0] exp_no);
        for (int k = 0; k < n; k++) begin
            step(bits[n-1-k]);
            check_eq({tag, "_ov"}, 32'(out_ov), 32'(exp_ov[n-1-k]));
            check_eq({tag, "_no"}, 32'(out_no), 32'(exp_no[n-1-k]));
        end
    endtask

    initial begin
        logic [3:0] pat;
        pat = PATTERN;

        // Held in reset with the clock running and input toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_s = ~in_s;
            @(posedge clk);
            #1;
            check_eq("hold_out_ov", 32'(out_ov), 32'd0);
            check_eq("hold_out_no", 32'(out_no), 32'd0);
            check_eq("hold_state", 32'(dut_ov.r_state), 32'(S0));
        end
        @(negedge clk);
        rst  = 1'b1;
        in_s = 1'b0;

        run_vec("basic", 16'b10110, 5, 16'b00010, 16'b00010);

        do_reset();
        run_vec("overlap", 16'b1011011, 7, 16'b0001001, 16'b0001000);

        do_reset();
        run_vec("near_a", 16'b100, 3, 16'b000, 16'b000);
        check_eq("near_s2_to_s0", 32'(dut_ov.r_state), 32'(S0));
        run_vec("near_b", 16'b111010, 6, 16'b000000, 16'b000000);

        // Asynchronous reset between edges discards the 101 prefix.
        do_reset();
        run_vec("mid_pre", 16'b101, 3, 16'b000, 16'b000);
        check_eq("mid_s3", 32'(dut_ov.r_state), 32'(S3));
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_async_state", 32'(dut_ov.r_state), 32'(S0));
        check_eq("mid_async_out", 32'(out_ov), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1);
        check_eq("mid_post_out_ov", 32'(out_ov), 32'd0);
        check_eq("mid_post_out_no", 32'(out_no), 32'd0);
        check_eq("mid_post_state", 32'(dut_ov.r_state), 32'(S1));

`ifdef MOORE_SEC_DETCNT_EN
        do_reset();
        check_eq("cnt_clear", 32'(cnt_ov), 32'd0);
        for (int r = 0; r < 3; r++) begin
            for (int j = 3; j >= 0; j--) step(pat[j]);
        end
        check_eq("cnt3_ov", 32'(cnt_ov), 32'd3);
        check_eq("cnt3_no", 32'(cnt_no), 32'd3);
        do_reset();
        check_eq("cnt_reset", 32'(cnt_ov), 32'd0);
        for (int r = 0; r < 300; r++) begin
            for (int j = 3; j >= 0; j--) step(pat[j]);
        end
        check_eq("cnt_sat_ov", 32'(cnt_ov), 32'd255);
        check_eq("cnt_sat_no", 32'(cnt_no), 32'd255);
`else
        for (int j = 3; j >= 0; j--) step(pat[j]);
        check_eq("pkg_pattern_ov", 32'(out_ov), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
